// File: rtl/fxp_pkg.sv
// fxp_pkg: shared fixed-point helpers, saturation limits and operation encoding
package fxp_pkg;
  typedef enum logic {FXP_ADD, FXP_SUB} fxp_op_e;
  function automatic int fxp_imax(int x, int y);
    return x > y ? x : y;
  endfunction
  function automatic int fxp_im(int ia, int ib);
    return fxp_imax(ia, ib);
  endfunction
  function automatic int fxp_fm(int fa, int fb);
    return fxp_imax(fa, fb);
  endfunction
  function automatic int fxp_sw(int ia, int fa, int ib, int fb);
    return fxp_im(ia, ib) + fxp_fm(fa, fb) + 1;
  endfunction
  function automatic longint fxp_max(int i, int f);
    return (longint'(1) <<< (i + f - 1)) - 1;
  endfunction
  function automatic longint fxp_min(int i, int f);
    return -(longint'(1) <<< (i + f - 1));
  endfunction
endpackage

// File: rtl/fxp_round_sat.sv
// fxp_round_sat: combinational requantise and saturate, round-half-up when FXP_ROUND_EN is defined
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int II = 5,
  parameter int FI = 5,
  parameter int OI = 4,
  parameter int OF = 4
) (
  input  logic [II+FI-1:0] x,
  output logic [OI+OF-1:0] y,
  output logic             ovf,
  output logic             udf
);
  localparam int OW = OI + OF;
  localparam int RW = fxp_imax(II + 1, OI) + OF;
  localparam longint MAXV = fxp_max(OI, OF);
  localparam longint MINV = fxp_min(OI, OF);
  logic signed [RW-1:0] r;
  generate
    if (OF < FI) begin : g_drop
      localparam int D = FI - OF;
      logic signed [RW+D-1:0] xe;
      assign xe = (RW + D)'($signed(x));
`ifdef FXP_ROUND_EN
      logic signed [RW+D-1:0] xr;
      assign xr = xe + (RW + D)'(1 << (D - 1));
      assign r = RW'(xr >>> D);
`else
      assign r = RW'(xe >>> D);
`endif
    end else begin : g_pad
      assign r = RW'($signed(x)) <<< (OF - FI);
    end
  endgenerate
  always_comb begin
    ovf = longint'(r) > MAXV;
    udf = longint'(r) < MINV;
    y = ovf ? OW'(MAXV) : udf ? OW'(MINV) : r[OW-1:0];
  end
endmodule

// File: rtl/fxp_addsub_pipe.sv
// fxp_addsub_pipe: 3-stage saturating fixed-point add/sub with valid/ready, rounding via FXP_ROUND_EN
module fxp_addsub_pipe
  import fxp_pkg::*;
#(
  parameter int IA = 4,
  parameter int FA = 5,
  parameter int IB = 3,
  parameter int FB = 5,
  parameter int IO = 4,
  parameter int FO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IA+FA-1:0] a,
  input  logic [IB+FB-1:0] b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IO+FO-1:0] sum,
  output logic             ovf,
  output logic             udf,
  input  logic             clr_flags,
  output logic             ovf_sticky,
  output logic             udf_sticky
);
  localparam int IM = fxp_im(IA, IB);
  localparam int FM = fxp_fm(FA, FB);
  localparam int SW = fxp_sw(IA, FA, IB, FB);
  localparam int OW = IO + FO;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [SW-1:0] a1_q, a1_d, b1_q, b1_d, s2_q, s2_d, a_al, b_al;
  logic [OW-1:0] sum_q, sum_d, rs_sum;
  logic ovf_q, ovf_d, udf_q, udf_d, rs_ovf, rs_udf;
  logic ovfs_q, ovfs_d, udfs_q, udfs_d;
  logic adv;
  fxp_op_e op;
  fxp_round_sat #(.II(IM + 1), .FI(FM), .OI(IO), .OF(FO)) u_rs (
    .x(s2_q), .y(rs_sum), .ovf(rs_ovf), .udf(rs_udf)
  );
  always_comb begin
    op = fxp_op_e'(op_sub);
    adv = !v3_q | out_ready;
    a_al = SW'($signed(a)) <<< (FM - FA);
    b_al = SW'($signed(b)) <<< (FM - FB);
    v1_d = adv ? in_valid : v1_q;
    v2_d = adv ? v1_q : v2_q;
    v3_d = adv ? v2_q : v3_q;
    a1_d = (adv & in_valid) ? a_al : a1_q;
    b1_d = (adv & in_valid) ? (op == FXP_SUB ? -b_al : b_al) : b1_q;
    s2_d = (adv & v1_q) ? a1_q + b1_q : s2_q;
    sum_d = (adv & v2_q) ? rs_sum : sum_q;
    ovf_d = (adv & v2_q) ? rs_ovf : ovf_q;
    udf_d = (adv & v2_q) ? rs_udf : udf_q;
    ovfs_d = (v3_q & out_ready & ovf_q) | (ovfs_q & !clr_flags);
    udfs_d = (v3_q & out_ready & udf_q) | (udfs_q & !clr_flags);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      a1_q <= '0;
      b1_q <= '0;
      s2_q <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      ovfs_q <= 1'b0;
      udfs_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      a1_q <= a1_d;
      b1_q <= b1_d;
      s2_q <= s2_d;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      ovfs_q <= ovfs_d;
      udfs_q <= udfs_d;
    end
  end
  assign in_ready = adv;
  assign out_valid = v3_q;
  assign sum = sum_q;
  assign ovf = ovf_q;
  assign udf = udf_q;
  assign ovf_sticky = ovfs_q;
  assign udf_sticky = udfs_q;
endmodule

// File: doc/fxp_addsub_pipe.md
Name: fxp_addsub_pipe

Overview:
- Parametrised signed fixed-point add/subtract unit.
- Operands A and B each have their own integer/fraction format; the result is produced in a third, independently chosen format.
- Pipeline: 3 stages (align, add, round/saturate) with a valid/ready handshake.
- Saturates to output range with per-sample and sticky overflow/underflow flags; sits in the datapath between format-converting producers and DSP consumers.

Parameters:
- IA, 4, integer bits of A (incl. sign)
- FA, 5, fraction bits of A
- IB, 3, integer bits of B (incl. sign)
- FB, 5, fraction bits of B
- IO, 4, integer bits of result (incl. sign)
- FO, 4, fraction bits of result

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  unit accepts operands this cycle
- a  in  IA+FA  signed operand A
- b  in  IB+FB  signed operand B
- op_sub  in  1  0: A+B, 1: A-B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  IO+FO  signed saturated result
- ovf  out  1  this result saturated positive
- udf  out  1  this result saturated negative
- clr_flags  in  1  clear sticky flags
- ovf_sticky  out  1  any positive saturation since last clear
- udf_sticky  out  1  any negative saturation since last clear

Behaviour:
- Reset (rst=0, async): all stage valids, sum, ovf, udf, ovf_sticky and udf_sticky are 0; in_ready is 1 once rst is released. Reset mid-operation discards all in-flight samples.
- Internal widths: IM=max(IA,IB), FM=max(FA,FB). The sum uses IM+1 integer bits and FM fraction bits, so it can never wrap internally.
- Stage 1 (align):
  - Sign-extend both operands to IM integer bits and zero-pad to FM fraction bits.
  - If op_sub=1, negate B at width IM+FM+1. Negating the most-negative value must therefore be exact.
- Stage 2 (add): full-precision sum, width IM+FM+1.
- Stage 3 (round/saturate):
  - FO<FM: drop the lower FM-FO bits (truncate toward -inf, or round; see Optional Feature).
  - FO>=FM: zero-pad the fraction.
  - If the value is above the IO.FO maximum: sum=0 followed by all 1s, ovf=1.
  - If the value is below the minimum: sum=1 followed by all 0s, udf=1.
  - Otherwise pass the value through, with ovf=udf=0.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance.
  - When advance=1, all stages shift together. A transfer occurs when in_valid & in_ready.
  - When advance=0, every stage holds and sum/ovf/udf stay stable while out_valid=1.
  - Latency is 3 cycles from accepted input to out_valid, with no stalls. Throughput is 1 sample/cycle.
  - Bubbles (in_valid=0) propagate as invalid stages.
- Sticky flags:
  - Set when a result with ovf/udf is transferred (out_valid & out_ready).
  - Cleared by clr_flags. When clear and set coincide, set wins.
- Flags and sum are don't-care when out_valid=0, but must hold their last value (no X).

Optional Feature:
- Macro: FXP_ROUND_EN.
- Defined:
  - Stage 3 rounds to nearest, with ties rounding up: add 2^(FM-FO-1) at the dropped LSB position, then truncate.
  - The add is done at one extra integer bit, so rounding that crosses the maximum saturates and sets ovf.
- Undefined: plain truncation toward -inf. No rounding adder is generated.
- The macro has no effect when FO>=FM.

Decomposition:
- Shared package fxp_pkg holds:
  - function fxp_max(i,f) and fxp_min(i,f), returning the saturation limits
  - localparam helpers IM, FM and the internal sum width
  - enum fxp_op_e {FXP_ADD, FXP_SUB}
- One sub-module, fxp_round_sat:
  - purely combinational, stage-3 logic
  - parametrised by input I/F and output I/F
  - reusable by the planned multiplier

Test Plan:
- Basic add: a=9'h070 (3.5), b=8'h28 (1.25), op_sub=0 -> after 3 cycles sum=8'h4C (4.75), ovf=udf=0.
- Positive saturation: a=9'h0FF (7.96875), b=8'h7F (3.96875) -> sum=8'h7F, ovf=1, ovf_sticky=1 after transfer. Then clr_flags=1 in the same cycle as a second overflow transfer -> ovf_sticky remains 1.
- Negative saturation and subtract:
  - a=9'h100 (-8), b=8'h80 (-4), add -> sum=8'h80, udf=1.
  - Same operands with op_sub=1 -> sum=8'hC0 (-4), udf=0.
- Rounding boundary:
  - a=9'h0FF, b=0. Truncate build -> sum=8'h7F, ovf=0. FXP_ROUND_EN build -> sum=8'h7F, ovf=1.
  - a=9'h001, b=8'h01 -> 1/16 exact, sum=8'h01 in both builds.
- Backpressure: stream 5 back-to-back samples, hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 while blocked, no sample lost or duplicated, order preserved, sum stable while stalled.
- Reset mid-stream: assert rst with 3 samples in flight -> out_valid=0 immediately and sticky flags=0. The first post-reset sample appears with 3-cycle latency.
